// File: rtl/ga_pkg.sv
// Shared constants and types for the gate array CPU register block.
package ga_pkg;

  typedef logic [4:0] ink_t;

  localparam logic [1:0] FN_PEN  = 2'b00;
  localparam logic [1:0] FN_INK  = 2'b01;
  localparam logic [1:0] FN_CTRL = 2'b10;

  localparam ink_t BORDER_PEN  = 5'd16;
  localparam ink_t DEFAULT_INK = 5'h14;

endpackage

// File: rtl/ga_wr_sync.sv
// CPU write-strobe synchroniser with a matching data pipeline and a
// single-cycle commit on each new rising edge of the synchronised strobe.
module ga_wr_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  output logic              commit,
  output logic [DATA_W-1:0] commit_data
);

  logic                   armed;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DATA_W-1:0]      data_q [SYNC_STAGES];

  // armed blocks a strobe still held high across reset from looking new
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      sync_q <= '0;
      commit <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) data_q[i] <= '0;
    end else begin
      armed     <= armed | ~strobe;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], strobe & armed};
      data_q[0] <= data;
      for (int i = 1; i < int'(SYNC_STAGES); i++) data_q[i] <= data_q[i-1];
      // registered form of (synchronised strobe & ~its previous value)
      commit <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign commit_data = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/ga_cpu_regs.sv
// Gate array CPU register file: pen select, palette, mode and ROM control,
// with a registered palette lookup for the pixel path.
module ga_cpu_regs
  import ga_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter ink_t        RESET_INK   = DEFAULT_INK,
  parameter int unsigned NUM_PENS    = 17
) (
  input  logic       CLK16,
  input  logic       RESET_n,
  input  logic       IORQ_n,
  input  logic       WR_n,
  input  logic       M1_n,
  input  logic       A15,
  input  logic       A14,
  input  logic [7:0] D,
  input  logic       MODE_SYNC,
  input  logic [4:0] PIX_PEN,
  output ink_t       INK,
  output logic [1:0] MODE,
  output logic       LROM_DIS,
  output logic       HROM_DIS,
  output logic       IRQ_RESET
);

  logic       wr_q_c;
  logic       commit;
  logic [7:0] commit_data;
  logic       unused_bit;
  logic       ms_q;
  logic       mode_fall_c;
  ink_t       rd_idx_c;
  ink_t       pen_sel;
  logic [1:0] pending_mode;
  ink_t       palette [NUM_PENS];

  assign wr_q_c      = ~IORQ_n & ~WR_n & M1_n & ~A15 & A14;
  assign mode_fall_c = ms_q & ~MODE_SYNC;
  assign rd_idx_c    = PIX_PEN[4] ? BORDER_PEN : PIX_PEN;
  assign unused_bit  = commit_data[5];

  ga_wr_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DATA_W     (8)
  ) u_wr_sync (
    .clk        (CLK16),
    .rst_n      (RESET_n),
    .strobe     (wr_q_c),
    .data       (D),
    .commit     (commit),
    .commit_data(commit_data)
  );

  // Register state; a mode apply in the commit cycle sees the old pending mode
  always_ff @(posedge CLK16) begin
    if (!RESET_n) begin
      pen_sel      <= '0;
      pending_mode <= '0;
      MODE         <= '0;
      LROM_DIS     <= 1'b0;
      HROM_DIS     <= 1'b0;
      IRQ_RESET    <= 1'b0;
      INK          <= RESET_INK;
      ms_q         <= 1'b0;
      for (int i = 0; i < int'(NUM_PENS); i++) palette[i] <= RESET_INK;
    end else begin
      ms_q      <= MODE_SYNC;
      IRQ_RESET <= 1'b0;
      INK       <= palette[rd_idx_c];
      if (mode_fall_c) MODE <= pending_mode;
      if (commit) begin
        case (commit_data[7:6])
          FN_PEN:  pen_sel <= commit_data[4] ? BORDER_PEN : {1'b0, commit_data[3:0]};
          FN_INK:  palette[pen_sel] <= commit_data[4:0];
          FN_CTRL: begin
            pending_mode <= commit_data[1:0];
            LROM_DIS     <= commit_data[2];
            HROM_DIS     <= commit_data[3];
            IRQ_RESET    <= commit_data[4];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
